collision_arbiter: RTL and testbench

Shares one sequential bounding-box collision checker among five requesters: the four character movement controllers (mage, gunman, swordman, fistman) and the projectile controller. It grants one requester at a time, round-robin, and snapshots the requester's test position and all four character positions. It then compares the test box against one character per cycle and returns a hit vector, an out-of-bounds flag and a move-allowed verdict. It sits between the movement/projectile controllers and the health manager, replacing per-controller collision logic.

---
 rtl/collision_arbiter.sv | 155 +++++++++++++++
 tb/tb_collision_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/collision_arbiter.sv
// Round-robin arbiter sharing one sequential AABB collision checker among four characters and the projectile.
// Latency: request sampled at E0, grant after E0, one character per cycle at E1-E4, done/results registered after E5.
// Backpressure: req is a held level; losers wait in IDLE, and a winner is never aborted except by rst.
//
// Ports: debouncingclock/rst (sync, active high); req/req_x/req_y per requester (10-bit fields);
// proj_owner selects the character the projectile must not hit; tgt_x/tgt_y are the live character positions;
// gnt/done one-hot per requester; hit_vec/oob/move_allowed are the verdict, valid with done and held afterwards.
module collision_arbiter #(
    parameter int NUM_REQ = 5,
    parameter int BOX_W   = 20,
    parameter int BOX_H   = 20,
    parameter int XLIMIT  = 319,
    parameter int YLIMIT  = 239
) (
    input  logic                   debouncingclock,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*10-1:0]  req_x,
    input  logic [NUM_REQ*10-1:0]  req_y,
    input  logic [1:0]             proj_owner,
    input  logic [39:0]            tgt_x,
    input  logic [39:0]            tgt_y,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     done,
    output logic [3:0]             hit_vec,
    output logic                   oob,
    output logic                   move_allowed,
    output logic                   busy
);
    localparam int IW = $clog2(NUM_REQ);
    localparam logic [10:0] BW    = 11'(BOX_W);
    localparam logic [10:0] BH    = 11'(BOX_H);
    localparam logic [10:0] OOB_X = 11'(XLIMIT - BOX_W);
    localparam logic [10:0] OOB_Y = 11'(YLIMIT - BOX_H);

    typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] win_q;
    logic [1:0]    idx;
    logic [1:0]    self_idx;
    logic [3:0]    hit_acc;
    logic          oob_acc;
    logic [9:0]    box_x, box_y;
    logic [9:0]    tx_l [4];
    logic [9:0]    ty_l [4];

    // Unpacked views of the packed request coordinates
    logic [9:0]    rx [NUM_REQ];
    logic [9:0]    ry [NUM_REQ];
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            rx[i] = req_x[i*10 +: 10];
            ry[i] = req_y[i*10 +: 10];
        end
    end

    // First requester at or above rr_ptr, wrapping modulo NUM_REQ
    logic          arb_found;
    logic [IW-1:0] arb_win;
    logic [IW:0]   arb_sum;
    always_comb begin
        arb_found = 1'b0;
        arb_win   = '0;
        arb_sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            arb_sum = {1'b0, rr_ptr} + (IW+1)'(k);
            if (arb_sum >= (IW+1)'(NUM_REQ))
                arb_sum = arb_sum - (IW+1)'(NUM_REQ);
            if (!arb_found && req[arb_sum[IW-1:0]]) begin
                arb_found = 1'b1;
                arb_win   = arb_sum[IW-1:0];
            end
        end
    end

    // 11-bit compare so box+size never wraps back into range
    logic [10:0] bx11, by11, tx11, ty11;
    logic        overlap, oob_now;
    always_comb begin
        bx11    = {1'b0, box_x};
        by11    = {1'b0, box_y};
        tx11    = {1'b0, tx_l[idx]};
        ty11    = {1'b0, ty_l[idx]};
        overlap = (bx11 < tx11 + BW) && (bx11 + BW > tx11) &&
                  (by11 < ty11 + BH) && (by11 + BH > ty11);
        oob_now = (bx11 > OOB_X) || (by11 > OOB_Y);
    end

    assign busy = (state != IDLE);

    always_ff @(posedge debouncingclock) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            win_q        <= '0;
            gnt          <= '0;
            done         <= '0;
            hit_vec      <= '0;
            oob          <= 1'b0;
            move_allowed <= 1'b0;
            idx          <= '0;
            self_idx     <= '0;
            hit_acc      <= '0;
            oob_acc      <= 1'b0;
            box_x        <= '0;
            box_y        <= '0;
            for (int i = 0; i < 4; i++) begin
                tx_l[i] <= '0;
                ty_l[i] <= '0;
            end
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (arb_found) begin
                        gnt     <= NUM_REQ'(1) << arb_win;
                        win_q   <= arb_win;
                        box_x   <= rx[arb_win];
                        box_y   <= ry[arb_win];
                        for (int i = 0; i < 4; i++) begin
                            tx_l[i] <= tgt_x[i*10 +: 10];
                            ty_l[i] <= tgt_y[i*10 +: 10];
                        end
                        // The projectile must ignore the character that fired it
                        self_idx <= (arb_win == IW'(NUM_REQ-1)) ? proj_owner : arb_win[1:0];
                        hit_acc <= '0;
                        oob_acc <= 1'b0;
                        idx     <= '0;
                        state   <= CHECK;
                    end
                end
                CHECK: begin
                    hit_acc[idx] <= overlap && (idx != self_idx);
                    if (idx == 2'd0)
                        oob_acc <= oob_now;
                    idx <= idx + 2'd1;
                    if (idx == 2'd3)
                        state <= RESP;
                end
                RESP: begin
                    done         <= gnt;
                    hit_vec      <= hit_acc;
                    oob          <= oob_acc;
                    move_allowed <= ~oob_acc & ~|hit_acc;
                    gnt          <= '0;
                    rr_ptr       <= (win_q == IW'(NUM_REQ-1)) ? '0 : win_q + IW'(1);
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_collision_arbiter.sv
// Scoreboard bench for collision_arbiter: directed requests push expected verdicts, a negedge monitor pops on done.
// Latency: expected done cycle is the drive cycle + 6.
// Backpressure: requesters drop req in the done cycle unless a test deliberately holds it.
module tb_collision_arbiter;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [4:0]  req;
    logic [49:0] req_x, req_y;
    logic [1:0]  proj_owner;
    logic [39:0] tgt_x, tgt_y;
    logic [4:0]  gnt, done;
    logic [3:0]  hit_vec;
    logic        oob, move_allowed, busy;

    logic [9:0]  rxa [5];
    logic [9:0]  rya [5];
    logic [9:0]  tx  [4];
    logic [9:0]  ty  [4];
    assign req_x = {rxa[4], rxa[3], rxa[2], rxa[1], rxa[0]};
    assign req_y = {rya[4], rya[3], rya[2], rya[1], rya[0]};
    assign tgt_x = {tx[3], tx[2], tx[1], tx[0]};
    assign tgt_y = {ty[3], ty[2], ty[1], ty[0]};

    collision_arbiter dut (
        .debouncingclock(clk), .rst(rst), .req(req), .req_x(req_x), .req_y(req_y),
        .proj_owner(proj_owner), .tgt_x(tgt_x), .tgt_y(tgt_y), .gnt(gnt), .done(done),
        .hit_vec(hit_vec), .oob(oob), .move_allowed(move_allowed), .busy(busy)
    );

    typedef struct {
        int       winner;
        logic [3:0] hit;
        logic     oob;
        logic     ma;
        int       exp_cyc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: every done strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && done !== 5'd0) begin
            if (q.size() == 0) begin
                chk("unexpected_done", {27'd0, done}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_onehot", {27'd0, done}, 32'd1 << e.winner);
                chk("hit_vec", {28'd0, hit_vec}, {28'd0, e.hit});
                chk("oob", {31'd0, oob}, {31'd0, e.oob});
                chk("move_allowed", {31'd0, move_allowed}, {31'd0, e.ma});
                if (e.exp_cyc >= 0)
                    chk("done_latency", cyc, e.exp_cyc);
            end
        end
    end

    task automatic push_exp(input int r, input logic [3:0] h, input logic o, input int ec);
        exp_t e;
        e.winner  = r;
        e.hit     = h;
        e.oob     = o;
        e.ma      = ~o & ~|h;
        e.exp_cyc = ec;
        q.push_back(e);
    endtask

    task automatic set_tgt(input int i, input int x, input int y);
        tx[i] = 10'(x);
        ty[i] = 10'(y);
    endtask

    task automatic do_check(input int r, input int x, input int y, input logic [3:0] h, input logic o);
        logic got;
        @(negedge clk);
        rxa[r] = 10'(x);
        rya[r] = 10'(y);
        req[r] = 1'b1;
        push_exp(r, h, o, cyc + 6);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("gnt_after_latch", {27'd0, gnt}, 32'd1 << r);
                chk("busy_after_latch", {31'd0, busy}, 32'd1);
            end
            if (done[r]) begin
                got = 1'b1;
                break;
            end
        end
        req[r] = 1'b0;
        chk("done_seen", {31'd0, got}, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int base;
        int ndone;
        logic seen0, seen3;
        rst = 1'b1;
        req = '0;
        proj_owner = 2'd0;
        for (int i = 0; i < 5; i++) begin rxa[i] = '0; rya[i] = '0; end
        for (int i = 0; i < 4; i++) begin tx[i] = '0; ty[i] = '0; end
        repeat (3) @(negedge clk);
        chk("rst_gnt", {27'd0, gnt}, 32'd0);
        chk("rst_done", {27'd0, done}, 32'd0);
        chk("rst_hit_vec", {28'd0, hit_vec}, 32'd0);
        chk("rst_oob", {31'd0, oob}, 32'd0);
        chk("rst_move_allowed", {31'd0, move_allowed}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;

        // Single requester, self excluded
        set_tgt(0, 100, 100); set_tgt(1, 30, 40); set_tgt(2, 200, 50); set_tgt(3, 0, 0);
        do_check(1, 30, 40, 4'b0000, 1'b0);

        // Overlap with char 2, then edge-adjacent (strict compare, no hit)
        set_tgt(0, 95, 90); set_tgt(1, 200, 200); set_tgt(2, 100, 100); set_tgt(3, 0, 0);
        do_check(0, 95, 90, 4'b0100, 1'b0);
        do_check(0, 80, 100, 4'b0000, 1'b0);

        // Bounds
        set_tgt(0, 0, 0); set_tgt(1, 0, 0); set_tgt(3, 0, 0);
        do_check(2, 300, 0, 4'b0000, 1'b1);
        do_check(2, 299, 219, 4'b0000, 1'b0);
        do_check(2, 1023, 0, 4'b0000, 1'b1);
        do_check(2, 0, 220, 4'b0000, 1'b1);

        // Projectile fired by char 3, sitting on char 3 and overlapping char 0
        proj_owner = 2'd3;
        set_tgt(0, 60, 55); set_tgt(1, 200, 200); set_tgt(2, 300, 100); set_tgt(3, 50, 50);
        do_check(4, 50, 50, 4'b0001, 1'b0);

        // Round-robin with all five requests held from reset
        do_reset();
        proj_owner = 2'd0;
        set_tgt(0, 0, 0); set_tgt(1, 100, 0); set_tgt(2, 200, 0); set_tgt(3, 0, 100);
        for (int i = 0; i < 4; i++) begin rxa[i] = tx[i]; rya[i] = ty[i]; end
        rxa[4] = 10'd250; rya[4] = 10'd150;
        @(negedge clk);
        base = cyc;
        for (int k = 0; k < 6; k++)
            push_exp(k % 5, 4'b0000, 1'b0, base + 6 + 6*k);
        req = 5'h1F;
        ndone = 0;
        for (int i = 0; i < 60 && ndone < 6; i++) begin
            @(negedge clk);
            if (done != 5'd0) ndone++;
        end
        req = '0;
        chk("rr_all_done", ndone, 32'd6);

        // Reset in the second CHECK cycle (rr_ptr is 1 here)
        @(negedge clk);
        req[2] = 1'b1;
        @(negedge clk);
        chk("midrst_gnt_before", {27'd0, gnt}, 32'd4);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_gnt", {27'd0, gnt}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {27'd0, done}, 32'd0);
        rst = 1'b0;
        req = '0;
        repeat (8) @(negedge clk);

        // Fresh requests 0 and 3 together: rr_ptr back at 0 so 0 wins first
        @(negedge clk);
        push_exp(0, 4'b0000, 1'b0, cyc + 6);
        push_exp(3, 4'b0000, 1'b0, cyc + 12);
        req = 5'b01001;
        seen0 = 1'b0;
        seen3 = 1'b0;
        for (int i = 0; i < 40 && !(seen0 && seen3); i++) begin
            @(negedge clk);
            if (done[0]) begin seen0 = 1'b1; req[0] = 1'b0; end
            if (done[3]) begin seen3 = 1'b1; req[3] = 1'b0; end
        end
        req = '0;
        chk("post_rst_both_done", {30'd0, seen3, seen0}, 32'd3);

        repeat (10) @(negedge clk);
        chk("queue_empty", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
